ql_sync_fifo: RTL and testbench
===============================

Name: ql_sync_fifo

Overview:
Parametrised single-clock FIFO simulation and whitebox model for the QuickLogic fabric. It generalises the fixed 32-bit RAM/FIFO primitive to arbitrary width and power-of-two depth. It adds programmable almost-empty and almost-full levels, a fill count, sticky overflow/underflow error flags and a synchronous flush. It sits between fabric logic and the block-RAM mapping, and is the behavioural reference for FIFO inference.

Parameters:
WIDTH, 32, data width in bits (>=1)
DEPTH, 512, number of entries; must be a power of two, >=2
AW, $clog2(DEPTH), address width; derived, never overridden

Ports:
clk  input  1  clock, rising edge; clkbuf_sink
rst  input  1  reset, asynchronous, active-high
flush  input  1  synchronous clear of contents and error flags
wen  input  1  write request
wdata  input  WIDTH  write data
ren  input  1  read request
rdata  output  WIDTH  registered read data
rvalid  output  1  one-cycle pulse; rdata carries newly read word
count  output  AW+1  current fill level, 0..DEPTH
empty  output  1  count==0
full  output  1  count==DEPTH
ae_level  input  AW+1  almost-empty threshold
af_level  input  AW+1  almost-full threshold
almost_empty  output  1  count<=ae_level
almost_full  output  1  count>=af_level
overflow  output  1  sticky: write rejected
underflow  output  1  sticky: read rejected

Behaviour:
- Reset (async): wptr, rptr, count, rdata, rvalid, overflow and underflow go to 0. Flags follow from count (empty=1, full=0). Memory array is not reset.
- rd_acc = ren & !empty.
- wr_acc = wen & (!full | rd_acc). A simultaneous read frees a slot, so a write while full is accepted when a read is accepted in the same cycle.
- No fall-through: when empty, a simultaneous wen/ren writes the word and rejects the read.
- On wr_acc: mem[wptr] <= wdata; wptr increments and wraps naturally modulo DEPTH.
- On rd_acc: rdata <= mem[rptr]; rptr increments and wraps. rvalid is 1 in the following cycle only.
- Read latency is 1 clock from the accepting edge.
- rdata holds its value when there is no read, including across flush.
- count next = count + wr_acc - rd_acc. Simultaneous accept leaves count unchanged.
- empty, full, almost_empty and almost_full are combinational from count and the level inputs. Comparisons are unsigned at AW+1 bits.
- Level values outside 0..DEPTH are legal; they simply saturate flag behaviour (e.g. af_level=0 means almost_full is always 1).
- overflow <= 1 when wen & !wr_acc. underflow <= 1 when ren & !rd_acc. Both stay set until flush or rst.
- flush has top synchronous priority:
  - wptr, rptr, count, overflow and underflow go to 0 at the edge.
  - wen/ren in that cycle are ignored and do not set the error flags.
  - rvalid is 0 in the next cycle.
- rst asserted mid-operation discards in-flight reads: rvalid is 0 immediately.
- After rst deasserts, the first edge behaves as from the empty state.

Test Plan:
- WIDTH=8, DEPTH=8: rst, then write 0x11..0x88 on 8 consecutive cycles -> full=1 after the 8th edge, count=8, almost_full=1 with af_level=6; a 9th write sets overflow=1 and count stays 8.
- From full, read 8 times -> rdata sequence 0x11..0x88, each with rvalid one cycle after its ren edge; empty=1 after the last read; a further ren sets underflow=1 and rdata holds 0x88.
- Full FIFO, wen=ren=1 with wdata=0x99 -> both accepted, count stays 8, overflow stays 0; the word read back after 0x88 is 0x99.
- Empty FIFO, wen=ren=1 with wdata=0x42 -> count=1, rvalid=0 next cycle, underflow=1; next ren returns 0x42.
- Pointer wrap: 20 interleaved write/read pairs with incrementing data -> data returned in order with no loss across wrap, count never exceeds 1.
- flush with count=5 and overflow=1, and wen=1 in the same cycle -> count=0, empty=1, overflow=0, write ignored, rdata unchanged.
- Async rst mid-stream -> outputs clear immediately without waiting for a clock edge.

Source files
------------

// File: rtl/ql_sync_fifo.sv
// ql_sync_fifo: single-clock FIFO with registered read data, programmable
// almost-empty/almost-full levels, fill count, sticky error flags and a
// synchronous flush. Behavioural reference for fabric FIFO inference.
module ql_sync_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 512,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             wen,
    input  logic [WIDTH-1:0] wdata,
    input  logic             ren,
    output logic [WIDTH-1:0] rdata,
    output logic             rvalid,
    output logic [AW:0]      count,
    output logic             empty,
    output logic             full,
    input  logic [AW:0]      ae_level,
    input  logic [AW:0]      af_level,
    output logic             almost_empty,
    output logic             almost_full,
    output logic             overflow,
    output logic             underflow
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             rd_acc, wr_acc;
    logic             rd_do, wr_do;

    // Status flags are pure functions of the fill level and the programmed levels
    always_comb begin
        empty        = (count == '0);
        full         = (count == (AW+1)'(DEPTH));
        almost_empty = (count <= ae_level);
        almost_full  = (count >= af_level);
    end

    // Accept logic: a same-cycle read frees a slot for a write when full;
    // there is no fall-through, so a read while empty is always rejected.
    // Flush overrides both so nothing moves in the flush cycle.
    always_comb begin
        rd_acc = ren & ~empty;
        wr_acc = wen & (~full | rd_acc);
        rd_do  = rd_acc & ~flush;
        wr_do  = wr_acc & ~flush;
    end

    // Storage array, intentionally not reset
    always_ff @(posedge clk) begin
        if (wr_do) mem[wptr] <= wdata;
    end

    // Pointers and fill level; pointers wrap naturally since DEPTH is 2^AW
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_do) wptr <= wptr + AW'(1);
            if (rd_do) rptr <= rptr + AW'(1);
            if (wr_do && !rd_do)      count <= count + (AW+1)'(1);
            else if (rd_do && !wr_do) count <= count - (AW+1)'(1);
        end
    end

    // Registered read port; rdata holds when idle, including across flush
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata  <= '0;
            rvalid <= 1'b0;
        end else begin
            rvalid <= rd_do;
            if (rd_do) rdata <= mem[rptr];
        end
    end

    // Sticky error flags; requests during flush are ignored and do not set them
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (flush) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wen && !wr_acc) overflow  <= 1'b1;
            if (ren && !rd_acc) underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ql_sync_fifo.sv
// Directed self-checking bench for ql_sync_fifo at WIDTH=8, DEPTH=8.
module tb_ql_sync_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             clk, rst, flush, wen, ren;
    logic [WIDTH-1:0] wdata, rdata;
    logic             rvalid, empty, full, almost_empty, almost_full;
    logic             overflow, underflow;
    logic [AW:0]      count, ae_level, af_level;

    int n_tests = 0;
    int n_fail  = 0;

    ql_sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wen(wen), .wdata(wdata), .ren(ren),
        .rdata(rdata), .rvalid(rvalid), .count(count),
        .empty(empty), .full(full),
        .ae_level(ae_level), .af_level(af_level),
        .almost_empty(almost_empty), .almost_full(almost_full),
        .overflow(overflow), .underflow(underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one rising edge and settle away from it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; wen = 1'b0; ren = 1'b0; wdata = '0;
        ae_level = 4'd2; af_level = 4'd6;
        #12;
        // reset state
        chk("rst_count", count, 0);
        chk("rst_empty", empty, 1);
        chk("rst_full", full, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);
        chk("rst_ae", almost_empty, 1);
        chk("rst_af", almost_full, 0);
        step();
        rst = 1'b0;

        // fill 0x11..0x88
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; wdata = 8'((i + 1) * 17);
            step();
            chk("fill_count", count, i + 1);
            chk("fill_af", almost_full, (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae", almost_empty, (i + 1 <= 2) ? 1 : 0);
        end
        chk("fill_full", full, 1);
        // 9th write rejected
        wdata = 8'h99;
        step();
        wen = 1'b0;
        chk("ovf_set", overflow, 1);
        chk("ovf_count", count, 8);

        // drain
        for (int i = 0; i < 8; i++) begin
            ren = 1'b1;
            step();
            chk("drain_rdata", rdata, (i + 1) * 17);
            chk("drain_rvalid", rvalid, 1);
        end
        ren = 1'b0;
        chk("drain_empty", empty, 1);
        chk("drain_count", count, 0);
        step();
        chk("idle_rvalid", rvalid, 0);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("unf_set", underflow, 1);
        chk("unf_rvalid", rvalid, 0);
        chk("unf_rdata_hold", rdata, 8'h88);
        chk("ovf_sticky", overflow, 1);

        // clear flags, refill, then simultaneous read/write while full
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_ovf", overflow, 0);
        chk("flush_unf", underflow, 0);
        for (int i = 0; i < 8; i++) begin
            wen = 1'b1; wdata = 8'((i + 1) * 17);
            step();
        end
        chk("refill_full", full, 1);
        wen = 1'b1; ren = 1'b1; wdata = 8'h99;
        step();
        wen = 1'b0;
        chk("rw_full_count", count, 8);
        chk("rw_full_ovf", overflow, 0);
        chk("rw_full_rdata", rdata, 8'h11);
        chk("rw_full_rvalid", rvalid, 1);
        for (int i = 1; i < 9; i++) begin
            step();
            chk("rw_drain_rdata", rdata, (i < 8) ? (i + 1) * 17 : 8'h99);
        end
        ren = 1'b0;
        chk("rw_drain_empty", empty, 1);

        // simultaneous read/write while empty: no fall-through
        wen = 1'b1; ren = 1'b1; wdata = 8'h42;
        step();
        wen = 1'b0; ren = 1'b0;
        chk("rw_empty_count", count, 1);
        chk("rw_empty_rvalid", rvalid, 0);
        chk("rw_empty_unf", underflow, 1);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("rw_empty_rdata", rdata, 8'h42);
        chk("rw_empty_rvalid2", rvalid, 1);
        chk("rw_empty_count2", count, 0);

        // pointer wrap: 20 write/read pairs
        flush = 1'b1;
        step();
        flush = 1'b0;
        for (int k = 0; k < 20; k++) begin
            wen = 1'b1; wdata = 8'(8'h30 + k);
            step();
            wen = 1'b0;
            chk("wrap_count_w", count, 1);
            ren = 1'b1;
            step();
            ren = 1'b0;
            chk("wrap_rdata", rdata, 8'h30 + k);
            chk("wrap_count_r", count, 0);
        end

        // flush with count=5, overflow set and a write in the same cycle
        for (int i = 0; i < 9; i++) begin
            wen = 1'b1; wdata = (i < 8) ? 8'(8'hA0 + i) : 8'hFF;
            step();
        end
        wen = 1'b0;
        chk("pre_flush_ovf", overflow, 1);
        for (int i = 0; i < 3; i++) begin
            ren = 1'b1;
            step();
        end
        ren = 1'b0;
        chk("pre_flush_count", count, 5);
        chk("pre_flush_rdata", rdata, 8'hA2);
        flush = 1'b1; wen = 1'b1; wdata = 8'h55;
        step();
        flush = 1'b0; wen = 1'b0;
        chk("flush_count", count, 0);
        chk("flush_empty", empty, 1);
        chk("flush_ovf2", overflow, 0);
        chk("flush_rdata_hold", rdata, 8'hA2);
        chk("flush_rvalid", rvalid, 0);
        step();
        chk("flush_wr_ignored", count, 0);

        // async reset mid-stream
        for (int i = 0; i < 2; i++) begin
            wen = 1'b1; wdata = 8'(8'hC0 + i);
            step();
        end
        wen = 1'b0; ren = 1'b1;
        step();
        ren = 1'b0;
        chk("pre_rst_rvalid", rvalid, 1);
        chk("pre_rst_rdata", rdata, 8'hC0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rvalid", rvalid, 0);
        chk("arst_count", count, 0);
        chk("arst_rdata", rdata, 0);
        chk("arst_empty", empty, 1);
        step();
        rst = 1'b0;
        wen = 1'b1; wdata = 8'h77;
        step();
        wen = 1'b0;
        chk("post_rst_count", count, 1);
        ren = 1'b1;
        step();
        ren = 1'b0;
        chk("post_rst_rdata", rdata, 8'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
